// File: rtl/brisc_pkg.sv
// Shared brisc types and constants used by the memory-side control blocks.
// Holds the STB drain FSM state encoding and the cache geometry.
package brisc_pkg;

    localparam int ADDR_LEN        = 32;
    localparam int NUM_CACHE_LINES = 8;
    localparam int LINE_BYTES      = 16;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_REQ,
        DRN_WAIT
    } stb_drain_state_e;

endpackage

// File: rtl/stb_drain_ctrl.sv
// Store-buffer drain sequencer for the single-ported D-cache, with line refill.
// Optional load-starvation timeout enabled by defining STB_STARVE_TIMEOUT_EN.
module stb_drain_ctrl
    import brisc_pkg::*;
#(
    parameter int NUM_ENTRIES     = NUM_CACHE_LINES,
    parameter int DRAIN_WATERMARK = 1,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           pipe_is_load_i,
    input  logic                           pipe_is_store_i,
    input  logic                           pipe_fence_i,
    input  logic [$clog2(NUM_ENTRIES):0]   stb_cnt_i,
    input  logic [ADDR_LEN-1:0]            stb_head_addr_i,
    input  logic                           cache_hit_i,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    output logic [ADDR_LEN-1:0]            cache_addr_o,
    output logic                           cache_wr_en_o,
    output logic                           stb_pop_o,
    output logic                           mem_req_o,
    output logic [ADDR_LEN-1:0]            mem_addr_o,
    output logic                           stall_o
);

    localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] WMARK    = CNT_W'(DRAIN_WATERMARK);

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("stb_drain_ctrl: STARVE_LIMIT must be at least 1");
    end

    stb_drain_state_e      state;
    logic                  mem_req_q;
    logic [ADDR_LEN-1:0]   mem_addr_q;

    logic idle;
    logic nonempty;
    logic full;
    logic load_eff;
    logic mem_op;
    logic want;
    logic attempt;
    logic hit_pop;
    logic miss;
    logic starve_force;

    // Decide whether the head may use the cache port this cycle.
    always_comb begin
        idle     = (state == DRN_IDLE);
        nonempty = (stb_cnt_i != '0);
        full     = (stb_cnt_i == FULL_CNT);
        load_eff = pipe_is_load_i & ~starve_force;
        mem_op   = load_eff | pipe_is_store_i;
        want     = (stb_cnt_i >= WMARK)
                 | pipe_fence_i
                 | (full & pipe_is_store_i)
                 | ~mem_op;
        attempt  = ~reset & enable & idle & nonempty & ~load_eff & want;
        hit_pop  = attempt & cache_hit_i;
        miss     = attempt & ~cache_hit_i;
    end

`ifdef STB_STARVE_TIMEOUT_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] SLIM = SCNT_W'(STARVE_LIMIT);

    logic [SCNT_W-1:0] starve_cnt;
    logic              load_blocked;

    assign load_blocked = ~reset & enable & idle & nonempty & pipe_is_load_i;
    assign starve_force = load_blocked & (starve_cnt == SLIM);

    // Count consecutive load-blocked cycles; any pop restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (hit_pop | starve_force) begin
            starve_cnt <= '0;
        end else if (load_blocked && starve_cnt != SLIM) begin
            starve_cnt <= starve_cnt + SCNT_W'(1);
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Outputs are forced quiet while reset is held.
    always_comb begin
        cache_addr_o  = reset ? '0 : stb_head_addr_i;
        cache_wr_en_o = hit_pop;
        stb_pop_o     = hit_pop;
        mem_req_o     = mem_req_q;
        mem_addr_o    = mem_addr_q;
        stall_o       = ~reset & (
                          ~idle
                        | (pipe_fence_i & (nonempty | ~idle))
                        | (pipe_is_store_i & full & ~hit_pop)
                        | starve_force);
    end

    // Drain FSM: IDLE drains, REQ holds the refill request, WAIT awaits the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DRN_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            unique case (state)
                DRN_IDLE: begin
                    if (miss) begin
                        state      <= DRN_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {stb_head_addr_i[ADDR_LEN-1:OFF_W],
                                       {OFF_W{1'b0}}};
                    end
                end
                DRN_REQ: begin
                    if (mem_gnt_i) begin
                        state     <= DRN_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                DRN_WAIT: begin
                    if (mem_rvalid_i) begin
                        state <= DRN_IDLE;
                    end
                end
                default: begin
                    state     <= DRN_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stb_drain_ctrl.sv
// Directed self-checking bench for stb_drain_ctrl.
// Starvation checks follow STB_STARVE_TIMEOUT_EN when it is defined.
module tb_stb_drain_ctrl;
    import brisc_pkg::*;

    localparam int NE = NUM_CACHE_LINES;
    localparam int CW = $clog2(NE) + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                pipe_is_load_i;
    logic                pipe_is_store_i;
    logic                pipe_fence_i;
    logic [CW-1:0]       stb_cnt_i;
    logic [ADDR_LEN-1:0] stb_head_addr_i;
    logic                cache_hit_i;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [ADDR_LEN-1:0] cache_addr_o;
    logic                cache_wr_en_o;
    logic                stb_pop_o;
    logic                mem_req_o;
    logic [ADDR_LEN-1:0] mem_addr_o;
    logic                stall_o;

    int n_cmp = 0;
    int n_err = 0;

    stb_drain_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .pipe_is_load_i  (pipe_is_load_i),
        .pipe_is_store_i (pipe_is_store_i),
        .pipe_fence_i    (pipe_fence_i),
        .stb_cnt_i       (stb_cnt_i),
        .stb_head_addr_i (stb_head_addr_i),
        .cache_hit_i     (cache_hit_i),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .cache_addr_o    (cache_addr_o),
        .cache_wr_en_o   (cache_wr_en_o),
        .stb_pop_o       (stb_pop_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .stall_o         (stall_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and checks happen at negedge + 1.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        enable          = 1'b1;
        pipe_is_load_i  = 1'b0;
        pipe_is_store_i = 1'b0;
        pipe_fence_i    = 1'b0;
        stb_cnt_i       = '0;
        cache_hit_i     = 1'b0;
        mem_gnt_i       = 1'b0;
        mem_rvalid_i    = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset           = 1'b1;
        stb_cnt_i       = 3;
        cache_hit_i     = 1'b1;
        stb_head_addr_i = 32'h0000_0040;
        step();
        step();
        #1;
        n_cmp++;
        if ({stb_pop_o, cache_wr_en_o, mem_req_o, stall_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {stb_pop_o, cache_wr_en_o, mem_req_o, stall_o});
        end
        n_cmp++;
        if (cache_addr_o !== 32'h0 || mem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h/%h want 0/0",
                     cache_addr_o, mem_addr_o);
        end
        @(negedge clk);
        reset     = 1'b0;
        stb_cnt_i = '0;
        #1;
        n_cmp++;
        if ({stb_pop_o, mem_req_o, stall_o} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset: got %b want 000",
                     {stb_pop_o, mem_req_o, stall_o});
        end
    endtask

    task automatic test_drain_burst();
        quiet();
        cache_hit_i     = 1'b1;
        stb_head_addr_i = 32'h0000_1000;
        for (int i = 3; i >= 0; i--) begin
            stb_cnt_i = CW'(i);
            #1;
            n_cmp++;
            if (stb_pop_o !== (i != 0) || cache_wr_en_o !== (i != 0)) begin
                n_err++;
                $display("FAIL burst_pop cnt=%0d: pop=%b wr=%b want %b",
                         i, stb_pop_o, cache_wr_en_o, i != 0);
            end
            step();
        end
        stb_cnt_i = 1;
        #1;
        n_cmp++;
        if (cache_addr_o !== 32'h0000_1000 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL burst_addr: addr=%h stall=%b want 00001000/0",
                     cache_addr_o, stall_o);
        end
        step();
    endtask

    task automatic test_enable_low();
        quiet();
        enable      = 1'b0;
        stb_cnt_i   = 2;
        cache_hit_i = 1'b1;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b0) begin
            n_err++;
            $display("FAIL enable_low: pop=%b want 0", stb_pop_o);
        end
        step();
        quiet();
    endtask

    task automatic test_load_block();
        quiet();
        stb_cnt_i      = 2;
        cache_hit_i    = 1'b1;
        pipe_is_load_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic exp_pop;
`ifdef STB_STARVE_TIMEOUT_EN
            exp_pop = (c == 9);
`else
            exp_pop = 1'b0;
`endif
            #1;
            n_cmp++;
            if (stb_pop_o !== exp_pop || stall_o !== exp_pop) begin
                n_err++;
                $display("FAIL load_block c=%0d: pop=%b stall=%b want %b/%b",
                         c, stb_pop_o, stall_o, exp_pop, exp_pop);
            end
            step();
            if (c == 9) stb_cnt_i = 1;
        end
        quiet();
    endtask

    task automatic test_refill();
        quiet();
        stb_cnt_i       = 1;
        stb_head_addr_i = 32'h0000_1234;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b0 || stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL refill_miss: pop=%b stall=%b req=%b want 0/0/0",
                     stb_pop_o, stall_o, mem_req_o);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            mem_gnt_i = (c == 2);
            #1;
            n_cmp++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_1230
                || stall_o !== 1'b1) begin
                n_err++;
                $display("FAIL refill_req c=%0d: req=%b addr=%h stall=%b want 1/00001230/1",
                         c, mem_req_o, mem_addr_o, stall_o);
            end
            step();
        end
        mem_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid_i = (c == 2);
            #1;
            n_cmp++;
            if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || stb_pop_o !== 1'b0) begin
                n_err++;
                $display("FAIL refill_wait c=%0d: req=%b stall=%b pop=%b want 0/1/0",
                         c, mem_req_o, stall_o, stb_pop_o);
            end
            step();
        end
        mem_rvalid_i = 1'b0;
        cache_hit_i  = 1'b1;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b1 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL refill_pop: pop=%b stall=%b want 1/0",
                     stb_pop_o, stall_o);
        end
        step();
        quiet();
    endtask

    task automatic test_full_store();
        quiet();
        stb_cnt_i       = CW'(NE);
        pipe_is_store_i = 1'b1;
        cache_hit_i     = 1'b1;
        stb_head_addr_i = 32'h0000_2008;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b1 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_hit: pop=%b stall=%b want 1/0", stb_pop_o, stall_o);
        end
        step();
        cache_hit_i = 1'b0;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b0 || stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_miss: pop=%b stall=%b want 0/1", stb_pop_o, stall_o);
        end
        step();
        mem_gnt_i = 1'b1;
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_2000 || stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_req: req=%b addr=%h stall=%b want 1/00002000/1",
                     mem_req_o, mem_addr_o, stall_o);
        end
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_wait: stall=%b want 1", stall_o);
        end
        step();
        mem_rvalid_i = 1'b0;
        cache_hit_i  = 1'b1;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b1 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_done: pop=%b stall=%b want 1/0", stb_pop_o, stall_o);
        end
        step();
        quiet();
    endtask

    task automatic test_fence();
        quiet();
        pipe_fence_i = 1'b1;
        cache_hit_i  = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            stb_cnt_i = CW'(i);
            #1;
            n_cmp++;
            if (stall_o !== (i != 0) || stb_pop_o !== (i != 0)) begin
                n_err++;
                $display("FAIL fence cnt=%0d: stall=%b pop=%b want %b/%b",
                         i, stall_o, stb_pop_o, i != 0, i != 0);
            end
            step();
        end
        quiet();
    endtask

    task automatic test_reset_in_wait();
        quiet();
        stb_cnt_i       = 1;
        stb_head_addr_i = 32'h0000_3454;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        stb_cnt_i = '0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_entry: stall=%b want 1", stall_o);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({stb_pop_o, cache_wr_en_o, mem_req_o, stall_o} !== 4'b0000
            || mem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_wait_out: ctl=%b addr=%h want 0000/0",
                     {stb_pop_o, cache_wr_en_o, mem_req_o, stall_o}, mem_addr_o);
        end
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_late_rvalid: stall=%b req=%b want 0/0",
                     stall_o, mem_req_o);
        end
        stb_cnt_i   = 1;
        cache_hit_i = 1'b1;
        #1;
        n_cmp++;
        if (stb_pop_o !== 1'b1 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_idle_drain: pop=%b stall=%b want 1/0",
                     stb_pop_o, stall_o);
        end
        step();
        quiet();
    endtask

    initial begin
        quiet();
        reset           = 1'b1;
        stb_head_addr_i = '0;
        @(negedge clk);
        test_reset();
        test_drain_burst();
        test_enable_low();
        test_load_block();
        test_refill();
        test_full_store();
        test_fence();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
